altsyncram_arbiter: RTL

//  Shares port A of one single-port altsyncram (operation_mode "SINGLE_PORT", clock0=clk) between two requesters.
//  - Per-cycle round-robin arbitration with valid/ready request handshakes.
//  - Read-data return pipeline matched to the RAM read latency.
//  - Optional post-reset clear sweep of the whole array.

---
 rtl/altsyncram_arbiter_pkg.sv | 23 ++
 rtl/altsyncram_rr_arb2.sv | 35 +++
 rtl/altsyncram_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/altsyncram_arbiter_pkg.sv
// Shared types for the two-requester single-port altsyncram arbiter.
// Struct field widths bound the ADDR_W/DATA_W range the arbiter is built for.
package altsyncram_arbiter_pkg;

  localparam int ARB_ADDR_W = 10;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_BE_W   = ARB_DATA_W / 8;

  typedef enum logic {INIT, RUN} state_t;

  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_BE_W-1:0]   be;
    logic [ARB_DATA_W-1:0] wdata;
  } ram_req_t;

  typedef struct packed {
    logic vld;
    logic id;
  } rsp_tok_t;

endpackage

// File: rtl/altsyncram_rr_arb2.sv
// Two-way round-robin grant with its own priority pointer.
// Latency: grant is combinational from req; pointer updates at the grant edge.
// Backpressure: en=0 withholds every grant and freezes the pointer.
module altsyncram_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic rr_ptr;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // Point at the requester that was not just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (|grant) begin
      rr_ptr <= grant[0];
    end
  end

endmodule

// File: rtl/altsyncram_arbiter.sv
// Shares port A of a single-port altsyncram between two requesters, with optional clear sweep.
// Latency: request to RAM is combinational; read data returns RD_LATENCY cycles after accept.
// Backpressure: req_ready only while running and granted; responses cannot be stalled.
module altsyncram_arbiter
  import altsyncram_arbiter_pkg::*;
#(
  parameter int                ADDR_W     = ARB_ADDR_W,
  parameter int                DATA_W     = ARB_DATA_W,
  parameter int                NUMWORDS   = 1024,
  parameter int                RD_LATENCY = 1,
  parameter bit                INIT_CLEAR = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_W-1:0]     req_addr,
  input  logic [2*(DATA_W/8)-1:0] req_be,
  input  logic [2*DATA_W-1:0]     req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic [ADDR_W-1:0]       ram_address,
  output logic [DATA_W/8-1:0]     ram_byteena,
  output logic                    ram_wren,
  output logic                    ram_rden,
  output logic [DATA_W-1:0]       ram_data,
  input  logic [DATA_W-1:0]       ram_q,
  output logic                    init_busy
);

  localparam int                BE_W      = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUMWORDS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic [1:0]        grant;
  logic              run;
  ram_req_t          req [2];
  ram_req_t          sel;
  rsp_tok_t          pipe [RD_LATENCY];
  rsp_tok_t          tok_in, tok_out;

  assign run       = (state == RUN);
  assign init_busy = (state == INIT);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      req[i].we    = req_we[i];
      req[i].addr  = ARB_ADDR_W'(req_addr[i*ADDR_W +: ADDR_W]);
      req[i].be    = ARB_BE_W'(req_be[i*BE_W +: BE_W]);
      req[i].wdata = ARB_DATA_W'(req_wdata[i*DATA_W +: DATA_W]);
    end
  end

  altsyncram_rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .req   (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;
  assign sel       = grant[1] ? req[1] : req[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT_CLEAR ? INIT : RUN;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) begin
        init_cnt <= init_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ram_address = '0;
    ram_byteena = '0;
    ram_wren    = 1'b0;
    ram_rden    = 1'b0;
    ram_data    = '0;
    tok_in      = '0;
    if (state == INIT) begin
      ram_address = init_cnt;
      ram_byteena = '1;
      ram_wren    = 1'b1;
      ram_data    = INIT_VALUE;
      if (init_cnt == LAST_ADDR) begin
        state_nxt = RUN;
      end
    end else if (|grant) begin
      ram_address = sel.addr[ADDR_W-1:0];
      if (sel.we) begin
        ram_wren    = 1'b1;
        ram_byteena = sel.be[BE_W-1:0];
        ram_data    = sel.wdata[DATA_W-1:0];
      end else begin
        ram_rden    = 1'b1;
        ram_byteena = '1;
        tok_in.vld  = 1'b1;
        tok_in.id   = grant[1];
      end
    end
  end

  // Token delay line tracks the RAM read latency so q and its owner line up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= tok_in;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign tok_out = pipe[RD_LATENCY-1];

  always_comb begin
    rsp_valid = 2'b00;
    rsp_rdata = '0;
    if (tok_out.vld && run) begin
      rsp_valid = tok_out.id ? 2'b10 : 2'b01;
      rsp_rdata = ram_q;
    end
  end

endmodule
